dmem_rr_arbiter: RTL
====================

# dmem_rr_arbiter

Two-master round-robin arbiter sharing one single-port, synchronous-read data RAM between the CPU data port (master 0) and a debug/loader port (master 1). It grants at most one access per cycle and forwards byte-lane writes. It returns read data with a fixed one-cycle latency, tagged to the granted master. Out-of-range addresses are rejected with an error response and never reach the RAM. The block sits between `cpu_top`'s stall-capable data interface and the data RAM macro.

## Interface
- `MEM_SIZE_WORDS`, 1024: RAM depth in 32-bit words; valid byte addresses are 0 .. 4*MEM_SIZE_WORDS-1.
- `ERR_RDATA`, 32'hdeadbeef: read data returned for a rejected access.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `m0_req`, `m1_req` in 1: access request, held until `mN_ready`.
- `m0_wen`, `m1_wen` in 4: byte-lane write enables; 4'b0000 means read.
- `m0_addr`, `m1_addr` in 32: byte address; bits [1:0] ignored for RAM indexing.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_ready`, `m1_ready` out 1: grant; request accepted this cycle.
- `m0_rvalid`, `m1_rvalid` out 1: response valid, one cycle after grant (reads and writes).
- `m0_rdata`, `m1_rdata` out 32: read data, valid with `mN_rvalid`.
- `m0_err`, `m1_err` out 1: address out of range, valid with `mN_rvalid`.
- `mem_en` out 1: RAM access strobe.
- `mem_wen` out 4: RAM byte write enables.
- `mem_addr` out 30: RAM word index, addr[31:2].
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data, valid the cycle after `mem_en`.

## Operation
- Priority pointer `last` (1 bit) records the last granted master. Reset value 1, so master 0 wins the first contention.
- Grant rules:
  - Only one requester: it is granted.
  - Both requesting: the master not equal to `last` is granted.
  - No requester: no grant, `last` unchanged.
- `last` updates on every grant. Two masters requesting continuously alternate 0,1,0,1…; neither waits more than 1 cycle.
- Granted access with address < 4*MEM_SIZE_WORDS:
  - `mem_en`=1; `mem_wen`, `mem_addr` and `mem_wdata` come from the winner.
- Granted access out of range:
  - `mem_en`=0, `mem_wen`=0. The access is still granted.
  - The response carries `err`=1 and `rdata`=ERR_RDATA; writes are dropped.
- Response register, captured at grant: `resp_valid`, `resp_id`, `resp_err`, `resp_isread`.
  - Next cycle, `m[resp_id]_rvalid`=1.
  - `rdata` = `mem_rdata` for an in-range read, ERR_RDATA on error, 0 for an in-range write.
  - The other master's rvalid/err=0 and rdata=0.
- A master may raise a new request in the same cycle its previous response is presented (back-to-back, 1 access/cycle throughput).
- Unused memory outputs are driven 0 when no grant occurs; no X propagation.

## Timing
- Grant path is combinational: `mN_ready` and `mem_*` depend on the same-cycle `mN_req`, `addr` and `last`.
- Response latency is exactly 1 cycle after the grant edge. There is no backpressure on responses.
- Reset (async assert, sync-released by the upstream reset logic):
  - `last`=1, `resp_valid`=0. All rvalid/err=0 and all rdata=0.
  - While `rst_n`=0: `ready`, `mem_en`, `mem_wen`=0 regardless of req.
- Reset mid-operation: a pending response is discarded (no rvalid after release). In-flight RAM writes granted before the reset edge complete at the RAM.
- Simultaneous request and response on the same master: both honoured in that cycle.
- Address boundary: 4*MEM_SIZE_WORDS-4 is in range; 4*MEM_SIZE_WORDS is out of range.

## Structure
- Shared package `mem_bus_pkg`:
  - WEN_READ=4'b0000 and WEN_WORD=4'b1111.
  - Default ERR_RDATA.
  - Request/response struct typedefs (wen, addr, wdata / rvalid, rdata, err).
- Sub-module `rr_arb2`: 2-input round-robin grant with registered `last` pointer. It is reused by the future instruction/data unified-memory arbiter. The top level adds range check, muxing and the response register.

## Test plan
- Single master: m0 writes 32'h00000001 to 0x100 with wen 1111, then reads 0x100. Required: m0_ready on each request, m0_rvalid 1 cycle later, read rdata=1, m1 outputs stay 0.
- Contention: m0 and m1 both hold reads for 4 cycles from reset. Required: grants 0,1,0,1; each rvalid is tagged to the correct master with matching mem_rdata.
- Byte lanes: m1 writes 32'hAABBCCDD with wen 0010 to a word preloaded 0, then reads it. Required: mem_wen=0010 and read returns 32'h0000CC00.
- Out of range: m0 reads 0x1000 (MEM_SIZE_WORDS=1024). Required: mem_en=0, next cycle m0_rvalid=1, m0_err=1, m0_rdata=32'hdeadbeef. Then 0xFFC reads normally with err=0.
- Back-to-back: m0 issues 3 consecutive reads (0x100, 0x104, 0x108) with req held. Required: 3 grants in 3 cycles and 3 rvalids in the following 3 cycles, in order.
- Reset mid-op: assert rst_n low asynchronously between a grant and its response. Required: no rvalid appears. After release, the first contention is granted to m0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus types and constants for the data-RAM arbiters.
package mem_bus_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WEN_W      = 4;
  localparam int unsigned WORD_IDX_W = ADDR_W - 2;

  localparam logic [WEN_W-1:0]  WEN_READ          = 4'b0000;
  localparam logic [WEN_W-1:0]  WEN_WORD          = 4'b1111;
  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hdeadbeef;

  typedef struct packed {
    logic [WEN_W-1:0]  wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } mem_resp_t;

  // Byte address to RAM word index; the low two bits select a byte lane only.
  function automatic logic [WORD_IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the registered pointer remembers the last winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  // Pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= gnt[1];
    end
  end

  // Grants are suppressed while reset is held, whatever the requests.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data RAM between the CPU
// data port (master 0) and the debug/loader port (master 1).
module dmem_rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned       MEM_SIZE_WORDS = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic [WEN_W-1:0]      m0_wen,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_ready,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic [WEN_W-1:0]      m1_wen,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_ready,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_err,
  output logic                  mem_en,
  output logic [WEN_W-1:0]      mem_wen,
  output logic [WORD_IDX_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  // Extra bit keeps the limit exact even when the RAM spans the whole space.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(MEM_SIZE_WORDS) << 2;

  logic [1:0]  gnt;
  mem_req_t    req0;
  mem_req_t    req1;
  mem_req_t    win;
  logic        granted;
  logic        in_range;

  logic        resp_valid;
  logic        resp_id;
  logic        resp_err;
  logic        resp_isread;
  logic [DATA_W-1:0] resp_rdata;
  mem_resp_t   resp0;
  mem_resp_t   resp1;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({m1_req, m0_req}),
    .gnt   (gnt)
  );

  // Winner selection and range check.
  always_comb begin
    req0     = '{wen: m0_wen, addr: m0_addr, wdata: m0_wdata};
    req1     = '{wen: m1_wen, addr: m1_addr, wdata: m1_wdata};
    win      = gnt[1] ? req1 : req0;
    granted  = |gnt;
    in_range = {1'b0, win.addr} < ADDR_LIMIT;
  end

  assign m0_ready = gnt[0];
  assign m1_ready = gnt[1];

  // RAM strobes: out-of-range accesses are granted but never reach the macro.
  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = WEN_READ;
    mem_addr  = '0;
    mem_wdata = '0;
    if (granted && in_range) begin
      mem_en    = 1'b1;
      mem_wen   = win.wen;
      mem_addr  = word_index(win.addr);
      mem_wdata = win.wdata;
    end
  end

  // Response descriptor captured at the grant edge; a reset discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_err    <= 1'b0;
      resp_isread <= 1'b0;
    end else begin
      resp_valid <= granted;
      if (granted) begin
        resp_id     <= gnt[1];
        resp_err    <= !in_range;
        resp_isread <= (win.wen == WEN_READ);
      end
    end
  end

  // Response steering: only the tagged master sees a non-zero response.
  always_comb begin
    resp_rdata = '0;
    if (resp_err) begin
      resp_rdata = ERR_RDATA;
    end else if (resp_isread) begin
      resp_rdata = mem_rdata;
    end

    resp0 = '0;
    resp1 = '0;
    if (resp_valid) begin
      if (resp_id) begin
        resp1 = '{rvalid: 1'b1, rdata: resp_rdata, err: resp_err};
      end else begin
        resp0 = '{rvalid: 1'b1, rdata: resp_rdata, err: resp_err};
      end
    end
  end

  assign m0_rvalid = resp0.rvalid;
  assign m0_rdata  = resp0.rdata;
  assign m0_err    = resp0.err;
  assign m1_rvalid = resp1.rvalid;
  assign m1_rdata  = resp1.rdata;
  assign m1_err    = resp1.err;

endmodule
